ysyx_22040750_ifu: RTL and testbench
====================================

# ysyx_22040750_ifu

Instruction fetch unit: the consumer side of the dnpc valid/ready handshake. It owns the architectural PC register and accepts each new dnpc from the next-PC generator. It fetches the instruction at that PC over a valid/ready instruction-memory port and hands pc/snpc/inst to the IF/ID register. Non-speculative, one instruction in flight: the next fetch starts only after the next-PC generator has resolved dnpc for the current instruction.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset
- NOP_INST, 32'h0000_0013, instruction presented on fetch fault or misaligned PC

Ports:
- I_clk  in  1  clock
- I_rst  in  1  synchronous, active-high reset
- I_dnpc_valid  in  1  dnpc from the next-PC generator is valid
- O_dnpc_ready  out  1  IFU accepts dnpc this cycle
- I_dnpc  in  32  next PC
- O_imem_req_valid  out  1  fetch request
- I_imem_req_ready  in  1  memory accepts request
- O_imem_addr  out  32  {pc[31:3], 3'b000}, doubleword aligned
- I_imem_rsp_valid  in  1  response valid
- O_imem_rsp_ready  out  1  IFU accepts response
- I_imem_rdata  in  64  response doubleword
- I_imem_rsp_err  in  1  bus error on response
- O_IF_ID_valid  out  1  pc/snpc/inst valid toward IF/ID
- I_IF_ID_ready  in  1  IF/ID accepts
- O_pc  out  32  PC of presented instruction
- O_snpc  out  32  O_pc + 4
- O_inst  out  32  instruction word
- O_fault  out  2  {misaligned, bus_err}, qualified by O_IF_ID_valid
- O_fetch_cnt  out  64  count of IF/ID handshakes

## Operation
- FSM with four states: S_REQ, S_RSP, S_OUT, S_NPC.
- S_REQ: O_imem_req_valid=1. On I_imem_req_ready, go to S_RSP.
- S_RSP: O_imem_rsp_ready=1. On I_imem_rsp_valid, latch the instruction and go to S_OUT.
  - Instruction = pc[2] ? rdata[63:32] : rdata[31:0].
  - If I_imem_rsp_err=1: inst=NOP_INST, fault[0]=1.
- S_OUT: O_IF_ID_valid=1; pc/snpc/inst/fault are held stable. On I_IF_ID_ready, increment O_fetch_cnt and go to S_NPC.
- S_NPC: O_dnpc_ready=1. On I_dnpc_valid:
  - pc<=I_dnpc and snpc<=I_dnpc+4; faults are cleared.
  - If I_dnpc[1:0]!=0: fault[1]=1, inst=NOP_INST, go to S_OUT with no memory request.
  - Otherwise go to S_REQ.
- O_dnpc_ready is 0 in all states except S_NPC. This makes the generator hold its dnpc in its internal buffer until the IFU is ready.
- Behaviour in states where the input is not expected:
  - I_imem_rsp_valid outside S_RSP is ignored.
  - I_dnpc_valid outside S_NPC is ignored.
- snpc is computed modulo 2^32; the wrap 32'hFFFF_FFFC+4 gives 0.
- O_fetch_cnt wraps modulo 2^64.

## Timing
- Reset values:
  - State is S_REQ, pc=RESET_PC, snpc=RESET_PC+4.
  - inst=NOP_INST, fault=0, O_fetch_cnt=0.
  - O_imem_req_valid=1 in the first cycle after reset deasserts.
  - O_IF_ID_valid=0, O_dnpc_ready=0, O_imem_rsp_ready=0.
- I_rst mid-operation (any state) returns to reset values in the next cycle. An outstanding response is then dropped: rsp_ready=0 until the new request has been accepted.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Zero-wait memory (req_ready=1, rsp_valid one cycle after acceptance) with IF/ID and dnpc always ready:
  - cycle 0 S_REQ, cycle 1 S_RSP, cycle 2 S_OUT, cycle 3 S_NPC, cycle 4 S_REQ.
  - Result: 4 cycles per instruction.
- Each wait cycle (req_ready low, rsp_valid low, IF_ID_ready low, dnpc_valid low) stretches the corresponding state by exactly one cycle.
- A misaligned dnpc takes 2 cycles per instruction (S_NPC -> S_OUT).

## Structure
- Shared package ysyx_22040750_pkg holds:
  - FSM state encodings (2 bits).
  - RESET_PC and NOP_INST defaults.
  - The O_fault bit positions.
- One sub-module, ysyx_22040750_imem_align. It is combinational and selects the 32-bit word from the 64-bit rdata by pc[2], substituting NOP_INST on error.
- The FSM, PC, snpc, the instruction register and the counter all live in the top block.

## Test plan
- Reset, then zero-wait memory returning rdata=64'h00100093_00000013 and all handshakes ready:
  - O_imem_addr=32'h8000_0000.
  - In S_OUT: O_pc=32'h8000_0000, O_snpc=32'h8000_0004, O_inst=32'h0000_0013.
  - Next fetch issued at cycle 4.
- dnpc=32'h8000_0004 with the same rdata -> O_imem_addr=32'h8000_0000, O_inst=32'h0010_0093.
- Backpressure: I_IF_ID_ready low 3 cycles -> O_IF_ID_valid held, pc/inst stable, O_fetch_cnt unchanged until the handshake, then +1.
- dnpc=32'h8000_0102 -> no imem request, O_fault=2'b10, O_inst=NOP_INST, O_IF_ID_valid in the cycle after acceptance.
- I_imem_rsp_err=1 -> O_fault=2'b01, O_inst=NOP_INST. The next aligned dnpc clears the fault.
- I_rst asserted in S_RSP with a response arriving the same cycle:
  - The response is ignored.
  - The next cycle shows the S_REQ reset values with addr=32'h8000_0000.
  - O_fetch_cnt=0.

Source files
------------

// File: rtl/ysyx_22040750_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// reset defaults and fault bit positions.
package ysyx_22040750_pkg;

  typedef enum logic [1:0] {
    S_REQ = 2'd0,
    S_RSP = 2'd1,
    S_OUT = 2'd2,
    S_NPC = 2'd3
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  // Bit positions inside the 2-bit fault vector {misaligned, bus_err}
  localparam int FAULT_BUS_ERR  = 0;
  localparam int FAULT_MISALIGN = 1;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_22040750_imem_align.sv
// Picks the 32-bit instruction out of a 64-bit memory doubleword and
// substitutes a NOP when the bus reported an error.
module ysyx_22040750_imem_align
  import ysyx_22040750_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        word_sel,
  input  logic [63:0] rdata,
  input  logic        err,
  output logic [31:0] inst
);

  // Upper word for pc[2]=1, lower otherwise; errors always yield the NOP
  always_comb begin
    inst = word_sel ? rdata[63:32] : rdata[31:0];
    if (err) begin
      inst = NOP_INST;
    end
  end

endmodule

// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit. Owns the architectural PC, fetches one
// instruction at a time over the imem port and presents pc/snpc/inst to
// IF/ID; the next fetch waits for dnpc from the next-PC generator.
//
// Handshakes: every port uses valid/ready; a transfer happens on a rising
// clock edge where both valid and ready are high. The IFU's valid/ready
// outputs are decoded from the FSM state only, so no input reaches an
// output combinationally.
module ysyx_22040750_ifu
  import ysyx_22040750_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_dnpc_valid,
  output logic        O_dnpc_ready,
  input  logic [31:0] I_dnpc,
  output logic        O_imem_req_valid,
  input  logic        I_imem_req_ready,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_rsp_valid,
  output logic        O_imem_rsp_ready,
  input  logic [63:0] I_imem_rdata,
  input  logic        I_imem_rsp_err,
  output logic        O_IF_ID_valid,
  input  logic        I_IF_ID_ready,
  output logic [31:0] O_pc,
  output logic [31:0] O_snpc,
  output logic [31:0] O_inst,
  output logic [1:0]  O_fault,
  output logic [63:0] O_fetch_cnt
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, snpc_q, inst_q;
  logic [1:0]  fault_q;
  logic [63:0] cnt_q;
  logic [31:0] aligned_inst;

  ysyx_22040750_imem_align #(
    .NOP_INST (NOP_INST)
  ) u_align (
    .word_sel (pc_q[2]),
    .rdata    (I_imem_rdata),
    .err      (I_imem_rsp_err),
    .inst     (aligned_inst)
  );

  // State register; reset always restarts with a fetch at RESET_PC
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; inputs not expected in the current state are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: if (I_imem_req_ready) state_d = S_RSP;
      S_RSP: if (I_imem_rsp_valid) state_d = S_OUT;
      S_OUT: if (I_IF_ID_ready)    state_d = S_NPC;
      S_NPC: begin
        if (I_dnpc_valid) begin
          state_d = is_misaligned(I_dnpc) ? S_OUT : S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // PC, instruction, fault and handshake counter updates
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pc_q    <= RESET_PC;
      snpc_q  <= RESET_PC + 32'd4;
      inst_q  <= NOP_INST;
      fault_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RSP: begin
          if (I_imem_rsp_valid) begin
            inst_q                 <= aligned_inst;
            fault_q[FAULT_BUS_ERR] <= I_imem_rsp_err;
          end
        end
        S_OUT: begin
          if (I_IF_ID_ready) begin
            cnt_q <= cnt_q + 64'd1;
          end
        end
        S_NPC: begin
          if (I_dnpc_valid) begin
            pc_q    <= I_dnpc;
            snpc_q  <= I_dnpc + 32'd4;
            fault_q <= '0;
            // A misaligned target is never fetched; present a NOP instead
            if (is_misaligned(I_dnpc)) begin
              fault_q[FAULT_MISALIGN] <= 1'b1;
              inst_q                  <= NOP_INST;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign O_imem_req_valid = (state_q == S_REQ);
  assign O_imem_rsp_ready = (state_q == S_RSP);
  assign O_IF_ID_valid    = (state_q == S_OUT);
  assign O_dnpc_ready     = (state_q == S_NPC);
  assign O_imem_addr      = {pc_q[31:3], 3'b000};
  assign O_pc             = pc_q;
  assign O_snpc           = snpc_q;
  assign O_inst           = inst_q;
  assign O_fault          = fault_q;
  assign O_fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Directed bench for the instruction fetch unit. The driver steps the DUT
// through each handshake and checks control outputs; a monitor compares
// every IF/ID handshake against an expected queue.
module tb_ysyx_22040750_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int W = 162; // {pc, snpc, inst, fault, cnt}

  logic        I_clk, I_rst;
  logic        I_dnpc_valid, O_dnpc_ready;
  logic [31:0] I_dnpc;
  logic        O_imem_req_valid, I_imem_req_ready;
  logic [31:0] O_imem_addr;
  logic        I_imem_rsp_valid, O_imem_rsp_ready;
  logic [63:0] I_imem_rdata;
  logic        I_imem_rsp_err;
  logic        O_IF_ID_valid, I_IF_ID_ready;
  logic [31:0] O_pc, O_snpc, O_inst;
  logic [1:0]  O_fault;
  logic [63:0] O_fetch_cnt;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_pc;
  logic [63:0] m_cnt;

  ysyx_22040750_ifu dut (
    .I_clk            (I_clk),
    .I_rst            (I_rst),
    .I_dnpc_valid     (I_dnpc_valid),
    .O_dnpc_ready     (O_dnpc_ready),
    .I_dnpc           (I_dnpc),
    .O_imem_req_valid (O_imem_req_valid),
    .I_imem_req_ready (I_imem_req_ready),
    .O_imem_addr      (O_imem_addr),
    .I_imem_rsp_valid (I_imem_rsp_valid),
    .O_imem_rsp_ready (O_imem_rsp_ready),
    .I_imem_rdata     (I_imem_rdata),
    .I_imem_rsp_err   (I_imem_rsp_err),
    .O_IF_ID_valid    (O_IF_ID_valid),
    .I_IF_ID_ready    (I_IF_ID_ready),
    .O_pc             (O_pc),
    .O_snpc           (O_snpc),
    .O_inst           (O_inst),
    .O_fault          (O_fault),
    .O_fetch_cnt      (O_fetch_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are checked 1ns after the edge
  task automatic cyc();
    @(posedge I_clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // DUT is in S_REQ; complete request and response phases
  task automatic do_fetch(input logic [63:0] rdata, input logic err,
                          input int req_w, input int rsp_w,
                          input logic [31:0] exp_inst, input logic [1:0] exp_fault,
                          input logic noise);
    for (int i = 0; i < req_w; i++) begin
      chk("req_valid_wait", O_imem_req_valid, 1);
      I_imem_rsp_valid = noise;
      I_imem_rdata     = {$urandom, $urandom};
      cyc();
    end
    I_imem_rsp_valid = 1'b0;
    chk("req_valid", O_imem_req_valid, 1);
    chk("rsp_ready_in_req", O_imem_rsp_ready, 0);
    chk("imem_addr", O_imem_addr, {m_pc[31:3], 3'b000});
    I_imem_req_ready = 1'b1;
    cyc();
    I_imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_w; i++) begin
      chk("rsp_ready_wait", O_imem_rsp_ready, 1);
      cyc();
    end
    chk("rsp_ready", O_imem_rsp_ready, 1);
    chk("req_valid_in_rsp", O_imem_req_valid, 0);
    I_imem_rsp_valid = 1'b1;
    I_imem_rdata     = rdata;
    I_imem_rsp_err   = err;
    exp_q.push_back({m_pc, m_pc + 32'd4, exp_inst, exp_fault, m_cnt});
    cyc();
    I_imem_rsp_valid = 1'b0;
    I_imem_rsp_err   = 1'b0;
  endtask

  // DUT is in S_OUT; hold off IF/ID for out_w cycles, then accept
  task automatic do_out(input int out_w, input logic noise);
    logic [31:0] pc0, inst0;
    logic [1:0]  f0;
    chk("if_id_valid", O_IF_ID_valid, 1);
    pc0 = O_pc; inst0 = O_inst; f0 = O_fault;
    for (int i = 0; i < out_w; i++) begin
      I_dnpc_valid = noise;
      I_dnpc       = 32'h1234_5671;
      cyc();
      chk("if_id_valid_hold", O_IF_ID_valid, 1);
      chk("dnpc_ready_in_out", O_dnpc_ready, 0);
      chk("pc_stable", O_pc, pc0);
      chk("inst_stable", O_inst, inst0);
      chk("fault_stable", O_fault, f0);
      chk("cnt_hold", O_fetch_cnt, m_cnt);
    end
    I_dnpc_valid  = 1'b0;
    I_IF_ID_ready = 1'b1;
    cyc();
    I_IF_ID_ready = 1'b0;
    m_cnt = m_cnt + 64'd1;
  endtask

  // DUT is in S_NPC; deliver the next pc after npc_w idle cycles
  task automatic do_npc(input logic [31:0] dnpc, input int npc_w);
    logic mis;
    mis = (dnpc[1:0] != 2'b00);
    chk("dnpc_ready", O_dnpc_ready, 1);
    chk("if_id_valid_in_npc", O_IF_ID_valid, 0);
    chk("cnt_after_hs", O_fetch_cnt, m_cnt);
    for (int i = 0; i < npc_w; i++) begin
      cyc();
      chk("dnpc_ready_wait", O_dnpc_ready, 1);
    end
    I_dnpc_valid = 1'b1;
    I_dnpc       = dnpc;
    m_pc         = dnpc;
    if (mis) exp_q.push_back({dnpc, dnpc + 32'd4, NOP, 2'b10, m_cnt});
    cyc();
    I_dnpc_valid = 1'b0;
    chk("dnpc_ready_after", O_dnpc_ready, 0);
    chk("req_valid_after_npc", O_imem_req_valid, !mis);
    chk("if_id_valid_after_npc", O_IF_ID_valid, mis);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge I_clk) begin
    if (!I_rst && O_IF_ID_valid && I_IF_ID_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %0h expected no output", O_pc);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_pc",    O_pc,        e[161:130]);
        chk("sb_snpc",  O_snpc,      e[129:98]);
        chk("sb_inst",  O_inst,      e[97:66]);
        chk("sb_fault", O_fault,     e[65:64]);
        chk("sb_cnt",   O_fetch_cnt, e[63:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    I_rst = 1'b1;
    I_dnpc_valid = 1'b0; I_dnpc = '0;
    I_imem_req_ready = 1'b0; I_imem_rsp_valid = 1'b0;
    I_imem_rdata = '0; I_imem_rsp_err = 1'b0;
    I_IF_ID_ready = 1'b0;
    m_pc = RST_PC; m_cnt = '0;
    repeat (3) cyc();

    // Reset values
    chk("rst_req_valid", O_imem_req_valid, 1);
    chk("rst_rsp_ready", O_imem_rsp_ready, 0);
    chk("rst_if_id_valid", O_IF_ID_valid, 0);
    chk("rst_dnpc_ready", O_dnpc_ready, 0);
    chk("rst_addr", O_imem_addr, 32'h8000_0000);
    chk("rst_pc", O_pc, 32'h8000_0000);
    chk("rst_snpc", O_snpc, 32'h8000_0004);
    chk("rst_inst", O_inst, NOP);
    chk("rst_fault", O_fault, 0);
    chk("rst_cnt", O_fetch_cnt, 0);
    I_rst = 1'b0;

    // Zero-wait fetch of the low word; next fetch at cycle 4
    do_fetch(64'h00100093_00000013, 1'b0, 0, 0, 32'h0000_0013, 2'b00, 1'b0);
    do_out(0, 1'b0);
    do_npc(32'h8000_0004, 0);

    // Same doubleword, upper word; IF/ID backpressure for 3 cycles
    do_fetch(64'h00100093_00000013, 1'b0, 0, 0, 32'h0010_0093, 2'b00, 1'b0);
    do_out(3, 1'b0);
    do_npc(32'h8000_0102, 2);

    // Misaligned target: presented straight away with NOP and fault 10
    do_out(0, 1'b0);
    do_npc(32'h8000_0010, 0);

    // Bus error with memory wait states and ignored stray inputs
    do_fetch(64'hdead_beef_cafe_f00d, 1'b1, 2, 2, NOP, 2'b01, 1'b1);
    do_out(1, 1'b1);
    do_npc(32'h8000_000C, 1);

    // Next aligned fetch clears the fault; pc[2]=1 picks upper word
    do_fetch(64'h12345678_9abcdef0, 1'b0, 0, 1, 32'h1234_5678, 2'b00, 1'b0);
    do_out(0, 1'b0);
    do_npc(32'hFFFF_FFFC, 0);

    // snpc wraps to zero
    do_fetch(64'h00a00513_00000000, 1'b0, 1, 0, 32'h00a0_0513, 2'b00, 1'b0);
    do_out(0, 1'b0);
    do_npc(32'h8000_0020, 0);

    // Reset in S_RSP while a response arrives: response dropped
    chk("mid_req_valid", O_imem_req_valid, 1);
    chk("mid_addr", O_imem_addr, 32'h8000_0020);
    I_imem_req_ready = 1'b1;
    cyc();
    I_imem_req_ready = 1'b0;
    chk("mid_rsp_ready", O_imem_rsp_ready, 1);
    I_rst = 1'b1;
    I_imem_rsp_valid = 1'b1;
    I_imem_rdata = 64'h11111111_22222222;
    cyc();
    I_rst = 1'b0;
    I_imem_rsp_valid = 1'b0;
    m_pc = RST_PC; m_cnt = '0;
    chk("mrst_req_valid", O_imem_req_valid, 1);
    chk("mrst_rsp_ready", O_imem_rsp_ready, 0);
    chk("mrst_if_id_valid", O_IF_ID_valid, 0);
    chk("mrst_addr", O_imem_addr, 32'h8000_0000);
    chk("mrst_pc", O_pc, 32'h8000_0000);
    chk("mrst_inst", O_inst, NOP);
    chk("mrst_cnt", O_fetch_cnt, 0);

    // Normal operation resumes from the reset PC
    do_fetch(64'h00100093_00000013, 1'b0, 0, 0, 32'h0000_0013, 2'b00, 1'b0);
    do_out(0, 1'b0);
    do_npc(32'h8000_0008, 0);

    repeat (2) cyc();
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
